// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size codes, FSM states and byte-lane helpers for the MEM-stage bus interface
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    function automatic int cnt_width(input int t);
        return $clog2(t);
    endfunction

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
        return size == SIZE_BYTE ? 4'b0001 << a :
               size == SIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SIZE_HALF && a[0]) || (size == SIZE_WORD && a != 2'b00) || size == 2'b11;
    endfunction

    function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] w);
        return size == SIZE_BYTE ? {4{w[7:0]}} :
               size == SIZE_HALF ? {2{w[15:0]}} : w;
    endfunction

endpackage

// File: rtl/mem_bus_timer.sv
// mem_bus_timer: wait-state counter that flags expiry once it sits at TIMEOUT-1
module mem_bus_timer
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = cnt_width(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + CW'(1);
    end

    assign expire = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage load/store unit; alignment check, byte lanes and wait-state bus handshake
module mem_bus_if
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] ld_data,
    output logic [3:0]  ld_be,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    state_t state, next;
    logic   mis, expire;

    assign mis = misaligned(req_size, req_addr[1:0]);

    mem_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == IDLE),
        .en     (state == BUS && !bus_ack),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state == IDLE ? (req_valid ? (mis ? DONE : BUS) : IDLE) :
               state == BUS  ? ((bus_ack || expire) ? DONE : BUS) : IDLE;
    end

    always_comb begin
        bus_req    = state == BUS;
        resp_valid = state == DONE;
        stall      = req_valid & ~resp_valid;
    end

    // Flags are only ever set on the edge into DONE, so they self-clear on the edge out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            ld_data   <= '0;
            ld_be     <= '0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid && !mis) begin
                bus_we    <= req_we;
                bus_addr  <= {req_addr[31:2], 2'b00};
                bus_be    <= be_gen(req_size, req_addr[1:0]);
                bus_wdata <= store_rep(req_size, req_wdata);
            end
            if (state == BUS && bus_ack && !bus_we) begin
                ld_data <= bus_rdata;
                ld_be   <= bus_be;
            end
            exc_adel <= state == IDLE && req_valid && mis && !req_we;
            exc_ades <= state == IDLE && req_valid && mis && req_we;
            bus_err  <= state == BUS && !bus_ack && expire;
        end
    end
endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed scoreboard bench for the MEM-stage bus interface
module tb_mem_bus_if;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall, resp_valid, exc_adel, exc_ades, bus_err, bus_req, bus_we;
    logic [31:0] ld_data, bus_addr, bus_wdata;
    logic [3:0]  ld_be, bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] baddr;
        logic [3:0]  bbe;
        logic [31:0] bwdata;
        logic        bwe;
        int          lat;
        int          nreq;
        logic        adel, ades, err;
        logic [31:0] ld;
        logic [3:0]  ldbe;
    } exp_t;

    exp_t sb[$];

    mem_bus_if #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
        .ld_data(ld_data), .ld_be(ld_be), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ackn = BUS cycle (1-based) on which the bridge acks; 0 = never
    task automatic run(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input int ackn, input logic [31:0] rdata,
                       input exp_t e);
        exp_t got;
        int   nb = 0;
        bit   done = 0;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        #1;
        chk("c0_stall", 32'(stall), 32'd1);
        chk("c0_clear", {29'd0, resp_valid, bus_err, exc_adel | exc_ades}, 32'd0);
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (bus_req) begin
                nb++;
                if (nb == 1) begin
                    chk("bus_addr", bus_addr, e.baddr);
                    chk("bus_be", 32'(bus_be), 32'(e.bbe));
                    chk("bus_wdata", bus_wdata, e.bwdata);
                    chk("bus_we", 32'(bus_we), 32'(e.bwe));
                end
                if (nb == ackn) begin
                    bus_ack = 1'b1;
                    bus_rdata = rdata;
                end
            end
            #1;
            if (resp_valid) begin
                got = sb.pop_front();
                chk("latency", 32'(cyc), 32'(got.lat));
                chk("req_cycles", 32'(nb), 32'(got.nreq));
                chk("done_stall", 32'(stall), 32'd0);
                chk("exc_adel", 32'(exc_adel), 32'(got.adel));
                chk("exc_ades", 32'(exc_ades), 32'(got.ades));
                chk("bus_err", 32'(bus_err), 32'(got.err));
                chk("ld_data", ld_data, got.ld);
                chk("ld_be", 32'(ld_be), 32'(got.ldbe));
                done = 1;
            end
        end
        if (!done) begin
            chk("resp_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        bus_ack = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("rst_ctl", {26'd0, stall, resp_valid, bus_req, bus_err, exc_adel, exc_ades}, 32'd0);
        chk("rst_bus", {bus_addr[27:0], bus_be}, 32'd0);
        chk("rst_ld", ld_data | {28'd0, ld_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // stray ack while idle must not start anything
        bus_ack = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_ack", {30'd0, bus_req, resp_valid}, 32'd0);
        bus_ack = 1'b0;

        run(0, 2'b00, 32'h0000_0103, 32'h77, 2, 32'hCAFE_F00D,
            '{32'h100, 4'b1000, 32'h7777_7777, 0, 3, 2, 0, 0, 0, 32'hCAFE_F00D, 4'b1000});
        run(1, 2'b01, 32'h22, 32'h1234_ABCD, 1, 32'hDEAD_0000,
            '{32'h20, 4'b1100, 32'hABCD_ABCD, 1, 2, 1, 0, 0, 0, 32'hCAFE_F00D, 4'b1000});
        run(0, 2'b10, 32'h6, 32'h0, 1, 32'h0,
            '{32'h0, 4'b0, 32'h0, 0, 1, 0, 1, 0, 0, 32'hCAFE_F00D, 4'b1000});
        run(1, 2'b01, 32'h5, 32'h0, 1, 32'h0,
            '{32'h0, 4'b0, 32'h0, 0, 1, 0, 0, 1, 0, 32'hCAFE_F00D, 4'b1000});
        run(0, 2'b11, 32'h0, 32'h0, 1, 32'h0,
            '{32'h0, 4'b0, 32'h0, 0, 1, 0, 1, 0, 0, 32'hCAFE_F00D, 4'b1000});
        run(1, 2'b10, 32'h40, 32'h1122_3344, 0, 32'h0,
            '{32'h40, 4'b1111, 32'h1122_3344, 1, 17, 16, 0, 0, 1, 32'hCAFE_F00D, 4'b1000});
        run(1, 2'b00, 32'h3, 32'h0000_00EE, 1, 32'h0,
            '{32'h0, 4'b1000, 32'hEEEE_EEEE, 1, 2, 1, 0, 0, 0, 32'hCAFE_F00D, 4'b1000});
        run(0, 2'b01, 32'h2, 32'h0, 3, 32'h1357_9BDF,
            '{32'h0, 4'b1100, 32'h0, 0, 4, 3, 0, 0, 0, 32'h1357_9BDF, 4'b1100});
        // back-to-back, each acked exactly on the last count before expiry
        run(0, 2'b10, 32'h80, 32'h0, 16, 32'h89AB_CDEF,
            '{32'h80, 4'b1111, 32'h0, 0, 17, 16, 0, 0, 0, 32'h89AB_CDEF, 4'b1111});
        run(0, 2'b00, 32'h41, 32'h0, 16, 32'h55AA_55AA,
            '{32'h40, 4'b0010, 32'h0, 0, 17, 16, 0, 0, 0, 32'h55AA_55AA, 4'b0010});

        // reset while waiting on the bridge
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_req", 32'(bus_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus_req), 32'd0);
        chk("async_rst_ld", ld_data | {28'd0, ld_be}, 32'd0);
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_no_resp", 32'(resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {30'd0, resp_valid, bus_req}, 32'd0);
        run(0, 2'b10, 32'h0, 32'h0, 1, 32'h0BAD_BEEF,
            '{32'h0, 4'b1111, 32'h0, 0, 2, 1, 0, 0, 0, 32'h0BAD_BEEF, 4'b1111});

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_bus_if.md
Name: mem_bus_if

Overview:
- Load/store bus interface unit in the MEM stage of the pipelined MIPS datapath. It sits directly upstream of the load-extension stage.
- Takes one memory request per instruction from the pipeline and checks its alignment. It generates the byte enables and the replicated store data, then runs a wait-state handshake with the system bridge (RAM and devices).
- Returns the raw read word plus its byte-enable mask for sign/zero extension downstream. Stalls the pipeline for the whole transaction.

Parameters:
- TIMEOUT, 16: maximum cycles bus_req stays high without bus_ack before the access is aborted with bus_err. Legal range 2..255.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  MEM stage holds a load/store; held high until resp_valid
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- stall  output  1  freeze pipeline; equals req_valid & ~resp_valid
- resp_valid  output  1  one-cycle pulse: access finished, results valid
- ld_data  output  32  raw read word latched from bus_rdata
- ld_be  output  4  byte-enable mask of the load, consumed by the extension stage
- exc_adel  output  1  load address error (valid with resp_valid)
- exc_ades  output  1  store address error (valid with resp_valid)
- bus_err  output  1  bus timeout (valid with resp_valid)
- bus_req  output  1  bridge request, held until ack or timeout
- bus_we  output  1  write strobe qualifier
- bus_addr  output  32  {req_addr[31:2],2'b00}
- bus_be  output  4  byte enables
- bus_wdata  output  32  replicated store data
- bus_ack  input  1  bridge completes the access this cycle
- bus_rdata  input  32  read word, sampled when bus_ack=1

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. All outputs 0, timeout counter 0.
- Reset mid-transaction aborts immediately: bus_req drops without waiting for ack, and no resp_valid is produced.
- Byte-enable rules:
  - Byte: be = 4'b0001 << addr[1:0].
  - Half: addr[1] ? 4'b1100 : 4'b0011.
  - Word: 4'b1111.
- Store data replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata unchanged.
- Misaligned when any of: half with addr[0]=1; word with addr[1:0]!=0; size=11.
- FSM states IDLE, BUS, DONE:
  - IDLE, req_valid=1 and aligned: latch we, be, word address, wdata → BUS. Counter is cleared.
  - IDLE, req_valid=1 and misaligned: no bus access. Set exc_adel (load) or exc_ades (store) → DONE.
  - IDLE, req_valid=0: stay.
  - BUS: bus_req=1 with registered bus_we/addr/be/wdata held stable.
    - bus_ack=1: latch bus_rdata into ld_data (loads only; stores leave ld_data unchanged) → DONE.
    - Otherwise counter increments. When the counter reaches TIMEOUT-1 with no ack, set bus_err → DONE.
    - An ack arriving in the same cycle as the counter reaching TIMEOUT-1 wins; no error is flagged.
  - DONE: resp_valid=1 for exactly one cycle. Next state is IDLE; req_valid is ignored in this cycle because the pipeline advances.
  - On leaving DONE, exc_adel, exc_ades and bus_err clear to 0.
- Pipeline contract: stall=0 in the DONE cycle, so the pipeline advances on that edge.
- Outputs held stable:
  - ld_data and ld_be hold until the next load completes.
  - bus_addr, bus_be, bus_wdata and bus_we are registered and hold their last values in IDLE; bus_req is 0 there.
- Latency: request seen in IDLE at cycle 0 → bus_req from cycle 1 → ack in cycle k (k≥1) → resp_valid in cycle k+1.
  - Best case: a 3-cycle MEM stage (ack in cycle 1).
  - Misaligned access: resp_valid in cycle 1.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. No bubble is required beyond DONE.
- A bus_ack received outside BUS is ignored.

Decomposition:
- Shared package mips_mem_pkg holds:
  - SIZE_BYTE/SIZE_HALF/SIZE_WORD constants
  - the state enum (IDLE, BUS, DONE)
  - function be_gen(size, addr[1:0]) returning 4 bits
  - function misaligned(size, addr[1:0])
  - function store_rep(size, wdata)
  - counter width $clog2(TIMEOUT)
- One sub-module: mem_bus_timer, a loadable timeout counter (clear, enable, expire output).

Test Plan:
- lb, addr 0x0000_0103, bridge acks 2 cycles after bus_req → bus_be=1000, bus_addr=0x100, resp_valid in cycle 3, ld_be=1000, ld_data=bus_rdata, stall high cycles 0-2.
- sh, addr 0x22, wdata 0x1234_ABCD, immediate ack → bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, resp_valid cycle 2, no exceptions.
- lw at addr 0x6, then sh at addr 0x5 → each gives resp_valid in cycle 1 (exc_adel=1 for lw, exc_ades=1 for sh), bus_req never asserted.
- sw with bus_ack held low → bus_req high exactly TIMEOUT=16 cycles, then bus_err=1 with resp_valid; next IDLE clears bus_err.
- rst_n pulsed low while in BUS after 3 wait cycles → bus_req=0 asynchronously, no resp_valid. After release, a fresh lw at addr 0x0 with ack completes normally with ld_be=1111.
- Back-to-back lw/lb with ack arriving on the TIMEOUT-1 count → ack wins, bus_err=0. Second request accepted on the cycle after the first DONE.
